// File: rtl/weight_update_pkg.sv
// Shared types, default widths and the saturating subtract used by the weight update engine.
package weight_update_pkg;

    localparam int WU_DATA_W = 16;
    localparam int WU_LR_W   = 16;
    localparam int WU_SHIFT  = 8;
    localparam int WU_ADDR_W = 10;
    localparam int WU_SUB_W  = WU_DATA_W + WU_LR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        CALC,
        WR,
        DONE
    } state_t;

    // w - d in one guard bit above the product width, clamped to the weight range
    function automatic logic signed [WU_DATA_W-1:0] sat_sub(
        input logic signed [WU_DATA_W-1:0]          w,
        input logic signed [WU_DATA_W+WU_LR_W-1:0]  d
    );
        logic signed [WU_SUB_W-1:0] diff;
        diff = WU_SUB_W'(w) - WU_SUB_W'(d);
        if (!diff[WU_SUB_W-1] && (|diff[WU_SUB_W-2:WU_DATA_W-1]))
            return {1'b0, {(WU_DATA_W-1){1'b1}}};
        else if (diff[WU_SUB_W-1] && !(&diff[WU_SUB_W-2:WU_DATA_W-1]))
            return {1'b1, {(WU_DATA_W-1){1'b0}}};
        else
            return diff[WU_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/wu_mac_sat.sv
// Registered weight/product capture and saturating update w - ((lr*g) >>> SHIFT).
module wu_mac_sat
    import weight_update_pkg::*;
#(
    parameter int DATA_W = WU_DATA_W,
    parameter int LR_W   = WU_LR_W,
    parameter int SHIFT  = WU_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] g_in,
    input  logic signed [LR_W-1:0]   lr_in,
    output logic signed [DATA_W-1:0] w_out
);

    localparam int P_W = DATA_W + LR_W;

    logic signed [DATA_W-1:0] w_q;
    logic signed [P_W-1:0]    p_q;
    logic signed [P_W-1:0]    p_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
            p_q <= '0;
        end else if (load) begin
            w_q <= w_in;
            p_q <= $signed(P_W'(lr_in)) * $signed(P_W'(g_in));
        end
    end

    // Arithmetic shift floors toward minus infinity
    always_comb begin
        p_sh  = p_q >>> SHIFT;
        w_out = sat_sub(w_q, p_sh);
    end

endmodule

// File: rtl/weight_update_engine.sv
// Job sequencer: per gradient read weight, compute saturated update, write back; reports progress.
module weight_update_engine
    import weight_update_pkg::*;
#(
    parameter int DATA_W = WU_DATA_W,
    parameter int LR_W   = WU_LR_W,
    parameter int SHIFT  = WU_SHIFT,
    parameter int ADDR_W = WU_ADDR_W
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_count,
    input  logic [LR_W-1:0]   cfg_lr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   upd_cnt,
    input  logic [DATA_W-1:0] grad_tdata,
    input  logic              grad_tvalid,
    output logic              grad_tready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = ADDR_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  count_q;
    logic [LR_W-1:0]   lr_q;
    logic [DATA_W-1:0] g_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            ptr     <= '0;
            count_q <= '0;
            lr_q    <= '0;
            g_q     <= '0;
            upd_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        count_q <= cfg_count;
                        lr_q    <= cfg_lr;
                        ptr     <= cfg_base;
                        upd_cnt <= '0;
                        if (cfg_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RD;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (grad_tvalid) begin
                        g_q   <= grad_tdata;
                        state <= WAIT;
                    end
                end
                WAIT: state <= CALC;
                CALC: state <= WR;
                WR: begin
                    upd_cnt <= upd_cnt + CNT_W'(1);
                    ptr     <= ptr + ADDR_W'(1);
                    if (upd_cnt + CNT_W'(1) == count_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read is issued in the same cycle the gradient handshake completes
    always_comb begin
        grad_tready = (state == RD);
        mem_en      = ((state == RD) && grad_tvalid) || (state == WR);
        mem_we      = (state == WR);
        mem_addr    = ptr;
    end

    wu_mac_sat #(
        .DATA_W (DATA_W),
        .LR_W   (LR_W),
        .SHIFT  (SHIFT)
    ) u_mac (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .load  (state == CALC),
        .w_in  (mem_rdata),
        .g_in  (g_q),
        .lr_in (lr_q),
        .w_out (mem_wdata)
    );

endmodule

// File: tb/tb_weight_update_engine.sv
// Scoreboard bench for weight_update_engine with a behavioural one-cycle-latency BRAM.
module tb_weight_update_engine;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        cfg_start = 1'b0;
    logic [9:0]  cfg_base = '0;
    logic [10:0] cfg_count = '0;
    logic [15:0] cfg_lr = '0;
    logic        busy, done;
    logic [10:0] upd_cnt;
    logic [15:0] grad_tdata = '0;
    logic        grad_tvalid = 1'b0;
    logic        grad_tready;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    weight_update_engine #(
        .DATA_W (16),
        .LR_W   (16),
        .SHIFT  (8),
        .ADDR_W (10)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_start   (cfg_start),
        .cfg_base    (cfg_base),
        .cfg_count   (cfg_count),
        .cfg_lr      (cfg_lr),
        .busy        (busy),
        .done        (done),
        .upd_cnt     (upd_cnt),
        .grad_tdata  (grad_tdata),
        .grad_tvalid (grad_tvalid),
        .grad_tready (grad_tready),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    logic [15:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge ACLK) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct { logic [9:0] addr; logic [15:0] data; } wr_t;
    typedef struct { int cyc; logic [10:0] cnt; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_done[$];
    logic [15:0] gq[$];
    logic [15:0] eq[$];

    int total = 0;
    int bad   = 0;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every BRAM write and every done pulse must match the head of its queue
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (mem_en && mem_we) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr=%h data=%h expected none", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                end else begin
                    dn_t d;
                    d = exp_done.pop_front();
                    check("done_cycle", 32'(cyc), 32'(d.cyc));
                    check("done_upd_cnt", 32'(upd_cnt), 32'(d.cnt));
                    check("done_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(negedge ACLK);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge ACLK);
        pre_we = 1'b0;
    endtask

    // Expectations are queued before the start edge so the monitor can never see an output first
    task automatic start_job(input logic [9:0] base, input logic [10:0] cnt, input logic [15:0] lr,
                             input int stall, input int nwr, input bit expect_done);
        @(negedge ACLK);
        cfg_base = base; cfg_count = cnt; cfg_lr = lr; cfg_start = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < nwr; i++) begin
            wr_t w;
            w.addr = base + 10'(i);
            w.data = eq[i];
            exp_wr.push_back(w);
        end
        if (expect_done) begin
            dn_t d;
            d.cyc = start_cyc + 4 * int'(cnt) + 1 + stall;
            d.cnt = cnt;
            exp_done.push_back(d);
        end
        @(negedge ACLK);
        cfg_start = 1'b0;
        cfg_base = ~base; cfg_count = 11'h3FF; cfg_lr = 16'h7FFF;
    endtask

    task automatic feed(input logic [15:0] g, input int stall);
        int n = 0;
        while (!grad_tready && n < 40) begin
            @(negedge ACLK);
            n++;
        end
        if (!grad_tready) begin
            total++; bad++;
            $display("FAIL tready_timeout: got tready=0 expected 1 within 40 cycles");
            return;
        end
        for (int i = 0; i < stall; i++) begin
            check("stall_mem_en", 32'(mem_en), 32'd0);
            check("stall_tready", 32'(grad_tready), 32'd1);
            @(negedge ACLK);
        end
        grad_tvalid = 1'b1; grad_tdata = g;
        @(negedge ACLK);
        grad_tvalid = 1'b0; grad_tdata = 16'hDEAD;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < limit) begin
            @(negedge ACLK);
            n++;
        end
        check("drain_wr_left", 32'(exp_wr.size()), 32'd0);
        check("drain_done_left", 32'(exp_done.size()), 32'd0);
        repeat (2) @(negedge ACLK);
    endtask

    task automatic run_job(input logic [9:0] base, input logic [10:0] cnt, input logic [15:0] lr, input int stall);
        start_job(base, cnt, lr, stall, int'(cnt), 1'b1);
        for (int i = 0; i < int'(cnt); i++) feed(gq[i], (i == 0) ? stall : 0);
        drain(100);
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tready", 32'(grad_tready), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_upd_cnt", 32'(upd_cnt), 32'd0);
        ARESETN = 1'b1;

        // basic update: 0x0200 - (0x0080*0x0100 >>> 8) = 0x0180
        preload(10'h000, 16'h0200);
        gq = '{16'h0100}; eq = '{16'h0180};
        run_job(10'h000, 11'd1, 16'h0080, 0);
        check("basic_mem", 32'(mem[0]), 32'h0180);
        check("basic_upd_cnt", 32'(upd_cnt), 32'd1);

        // positive then negative saturation
        preload(10'h010, 16'h7F00);
        preload(10'h011, 16'h8100);
        gq = '{16'h8000, 16'h7FFF}; eq = '{16'h7FFF, 16'h8000};
        run_job(10'h010, 11'd2, 16'h0100, 0);

        // address wrap with a 4-element burst
        preload(10'h3FE, 16'h0500); preload(10'h3FF, 16'h0500);
        preload(10'h000, 16'h0500); preload(10'h001, 16'h0500);
        gq = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        eq = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        run_job(10'h3FE, 11'd4, 16'h0100, 0);
        check("wrap_upd_cnt", 32'(upd_cnt), 32'd4);
        check("wrap_mem1", 32'(mem[1]), 32'h0400);

        // backpressure: three idle RD cycles
        preload(10'h020, 16'h0200);
        gq = '{16'h0100}; eq = '{16'h0180};
        run_job(10'h020, 11'd1, 16'h0080, 3);
        check("bp_mem", 32'(mem[10'h020]), 32'h0180);

        // zero-length job
        start_job(10'h030, 11'd0, 16'h0100, 0, 0, 1'b1);
        check("zero_mem_en", 32'(mem_en), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        drain(20);
        check("zero_upd_cnt", 32'(upd_cnt), 32'd0);

        // start while busy is ignored
        preload(10'h040, 16'h0100); preload(10'h041, 16'h0100);
        gq = '{16'h0100, 16'h0100}; eq = '{16'h0080, 16'h0080};
        start_job(10'h040, 11'd2, 16'h0080, 0, 2, 1'b1);
        cfg_start = 1'b1; cfg_count = 11'd5; cfg_base = 10'h100;
        feed(gq[0], 0);
        cfg_start = 1'b0;
        feed(gq[1], 0);
        drain(100);
        repeat (6) @(negedge ACLK);
        check("restart_upd_cnt", 32'(upd_cnt), 32'd2);
        check("restart_busy", 32'(busy), 32'd0);

        // reset while the third element waits on the BRAM read
        preload(10'h050, 16'h0300); preload(10'h051, 16'h0300); preload(10'h052, 16'h0300);
        gq = '{16'h0100, 16'h0100, 16'h0100}; eq = '{16'h0200, 16'h0200};
        start_job(10'h050, 11'd3, 16'h0100, 0, 2, 1'b0);
        feed(gq[0], 0);
        feed(gq[1], 0);
        feed(gq[2], 0);
        ARESETN = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tready", 32'(grad_tready), 32'd0);
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("midrst_upd_cnt", 32'(upd_cnt), 32'd0);
        check("midrst_writes_done", 32'(exp_wr.size()), 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (6) @(negedge ACLK);
        check("midrst_elem2_kept", 32'(mem[10'h052]), 32'h0300);
        check("midrst_elem1", 32'(mem[10'h051]), 32'h0200);

        // fresh job after the reset
        gq = '{16'h0100}; eq = '{16'h0200};
        run_job(10'h052, 11'd1, 16'h0100, 0);
        check("post_rst_mem", 32'(mem[10'h052]), 32'h0200);
        check("post_rst_upd_cnt", 32'(upd_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
